read_responder: RTL and testbench
=================================

Name: read_responder

Overview:
Return-path counterpart to the register write controller. Accepts a read request (register address) and fetches the 32-bit word from the register bank. Serialises address plus data into a UART_PACKET stream toward the UART transmitter. Sits between the register bank and the UART TX packetiser.

Parameters:
DATA_LENGTH, 4, data bytes per response (MSB first); Length field = DATA_LENGTH+1
SOURCE_ID, 8'h01, value driven on packet Source field
DEST_ID, 8'h00, value driven on packet Destination field
TIMEOUT, 255, max cycles to wait for ipRdValid before error response

Ports:
ipClk  input  1  system clock
ipReset  input  1  synchronous, active-high reset
ipRdRequest  input  1  one-cycle read request strobe
ipRdAddress  input  8  register address, sampled with ipRdRequest
opRdEnable  output  1  one-cycle read strobe to register bank
opRdAddress  output  8  address presented to register bank
ipRdData  input  32  read data from register bank
ipRdValid  input  1  ipRdData valid (any latency ≥1 cycle after opRdEnable)
ipTxReady  input  1  downstream accepts current byte when high
opTxStream  output  UART_PACKET  Source, Destination, Length, SoP, EoP, Data[7:0], Valid
opBusy  output  1  high from request accept until last byte accepted
opError  output  1  one-cycle pulse on read timeout

Behaviour:
- Reset (sync, registered internally like other controllers): state IDLE; opRdEnable=0, opRdAddress=0, opTxStream all fields 0, opBusy=0, opError=0, counters 0. Reset mid-packet abandons packet immediately (Valid drops next cycle, no EoP).
- Transfer rule: a byte is consumed only on a cycle where opTxStream.Valid && ipTxReady. Data/SoP/EoP held stable while Valid && !ipTxReady.
- States:
  IDLE: opBusy=0. On ipRdRequest: latch address into opRdAddress, pulse opRdEnable (next cycle), opBusy=1, -> WAIT_DATA.
  WAIT_DATA: timeout counter increments each cycle. On ipRdValid: latch ipRdData into shift register, -> SEND_ADDRESS. If counter reaches TIMEOUT without ipRdValid: load 32'hFFFFFFFF, pulse opError, -> SEND_ADDRESS. ipRdValid and timeout in same cycle: ipRdValid wins, no error.
  SEND_ADDRESS: Valid=1, SoP=1, EoP=0, Data=latched address, Source/Destination/Length from parameters. On accept -> SEND_DATA, byte counter = DATA_LENGTH.
  SEND_DATA: Valid=1, SoP=0, Data=shift register [31:24]. On accept: shift left 8, decrement counter. EoP=1 on the byte where counter==1. Accept of EoP byte -> IDLE, Valid=0, opBusy=0 same cycle as transition.
- ipRdRequest while opBusy=1: ignored (no queuing); requester must wait for opBusy low.
- ipRdRequest on the cycle the last byte is accepted: ignored (opBusy still high that cycle).
- ipRdValid outside WAIT_DATA: ignored.
- Latency: request -> opRdEnable 1 cycle; ipRdValid -> first Valid 1 cycle.
- Minimum packet time with ipTxReady tied high: DATA_LENGTH+1 consecutive Valid cycles.
- Length field constant (DATA_LENGTH+1) for every byte of the packet; Source/Destination constant.

Decomposition:
- Shared package Structures: existing UART_PACKET typedef; add localparams for default SOURCE_ID / DEST_ID and a RESPONDER_STATE enum (IDLE, WAIT_DATA, SEND_ADDRESS, SEND_DATA).
- Single module; no sub-module. Timeout counter and byte shifter stay inline.

Test Plan:
- Reset then request addr 8'h05, ipRdValid 2 cycles later with 32'hA1B2C3D4, ipTxReady=1 -> bytes 05(SoP),A1,B2,C3,D4(EoP), Length=5, Source=01, Dest=00, contiguous.
- Same request, ipTxReady toggling 1/0 -> identical byte sequence, each byte held stable while ready low, no duplicates or drops.
- Request with ipRdValid never asserted -> opError pulse at TIMEOUT cycles, packet 05,FF,FF,FF,FF, opBusy drops after EoP accept.
- Second ipRdRequest (addr 8'h09) during SEND_DATA -> ignored; only one packet for 8'h05; new request after opBusy=0 yields packet for 09.
- ipReset asserted after second data byte -> next cycle Valid=0, all outputs zero, state IDLE; subsequent request produces full correct packet.
- ipRdValid and timeout coincide -> real data sent, opError stays 0.

Source files
------------

// File: rtl/read_responder_pkg.sv
// ============================================================================
// read_responder_pkg : shared UART packet type, default IDs, responder states
// Rev 1.0
// ============================================================================
`default_nettype none

package read_responder_pkg;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic [7:0] Data;
    logic       Valid;
  } UART_PACKET;

  localparam logic [7:0] DEFAULT_SOURCE_ID = 8'h01;
  localparam logic [7:0] DEFAULT_DEST_ID   = 8'h00;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_DATA    = 2'd1,
    SEND_ADDRESS = 2'd2,
    SEND_DATA    = 2'd3
  } RESPONDER_STATE;

endpackage

`default_nettype wire

// File: rtl/read_responder.sv
// ============================================================================
// read_responder : fetches a register word and streams address+data as a
//                  UART_PACKET toward the TX packetiser
// Rev 1.0
// ============================================================================
`default_nettype none

module read_responder
  import read_responder_pkg::*;
#(
  parameter int         DATA_LENGTH = 4,
  parameter logic [7:0] SOURCE_ID   = DEFAULT_SOURCE_ID,
  parameter logic [7:0] DEST_ID     = DEFAULT_DEST_ID,
  parameter int         TIMEOUT     = 255
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic        ipRdRequest,
  input  logic [7:0]  ipRdAddress,
  output logic        opRdEnable,
  output logic [7:0]  opRdAddress,
  input  logic [31:0] ipRdData,
  input  logic        ipRdValid,
  input  logic        ipTxReady,
  output UART_PACKET  opTxStream,
  output logic        opBusy,
  output logic        opError
);

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);
  localparam int c_BC_W  = $clog2(DATA_LENGTH + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_BC_W-1:0]  c_BYTES        = c_BC_W'(DATA_LENGTH);
  localparam logic [c_BC_W-1:0]  c_LAST_BYTE    = c_BC_W'(1);
  localparam logic [7:0]         c_LENGTH       = 8'(DATA_LENGTH + 1);

  RESPONDER_STATE      r_state;
  RESPONDER_STATE      w_state_next;
  logic [c_CNT_W-1:0]  r_timeout_count;
  logic [c_BC_W-1:0]   r_byte_count;
  logic [31:0]         r_shift;
  logic                w_accept;
  logic                w_timeout;

  assign w_accept  = opTxStream.Valid && ipTxReady;
  // A valid response on the final wait cycle takes priority over the timeout.
  assign w_timeout = (r_state == WAIT_DATA) && !ipRdValid && (r_timeout_count == c_TIMEOUT_LAST);
  assign opBusy    = (r_state != IDLE);

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:         if (ipRdRequest) w_state_next = WAIT_DATA;
      WAIT_DATA:    if (ipRdValid || w_timeout) w_state_next = SEND_ADDRESS;
      SEND_ADDRESS: if (w_accept) w_state_next = SEND_DATA;
      SEND_DATA:    if (w_accept && (r_byte_count == c_LAST_BYTE)) w_state_next = IDLE;
      default:      w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      opRdEnable      <= 1'b0;
      opRdAddress     <= 8'h00;
      opError         <= 1'b0;
      r_timeout_count <= '0;
      r_byte_count    <= '0;
      r_shift         <= 32'h0;
    end else begin
      opRdEnable <= 1'b0;
      opError    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ipRdRequest) begin
            opRdAddress     <= ipRdAddress;
            opRdEnable      <= 1'b1;
            r_timeout_count <= '0;
          end
        end
        WAIT_DATA: begin
          if (ipRdValid) begin
            r_shift <= ipRdData;
          end else if (w_timeout) begin
            r_shift <= 32'hFFFF_FFFF;
            opError <= 1'b1;
          end else begin
            r_timeout_count <= r_timeout_count + 1'b1;
          end
        end
        SEND_ADDRESS: begin
          if (w_accept) r_byte_count <= c_BYTES;
        end
        SEND_DATA: begin
          if (w_accept) begin
            r_shift      <= {r_shift[23:0], 8'h00};
            r_byte_count <= r_byte_count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stream fields are decoded from registered state, so they are all zero outside a packet.
  always_comb begin
    opTxStream = '0;
    if ((r_state == SEND_ADDRESS) || (r_state == SEND_DATA)) begin
      opTxStream.Valid       = 1'b1;
      opTxStream.Source      = SOURCE_ID;
      opTxStream.Destination = DEST_ID;
      opTxStream.Length      = c_LENGTH;
      opTxStream.SoP         = (r_state == SEND_ADDRESS);
      opTxStream.EoP         = (r_state == SEND_DATA) && (r_byte_count == c_LAST_BYTE);
      opTxStream.Data        = (r_state == SEND_ADDRESS) ? opRdAddress : r_shift[31:24];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_read_responder.sv
// ============================================================================
// tb_read_responder : randomized self-checking bench for read_responder
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_read_responder;
  import read_responder_pkg::*;

  localparam int DLEN  = 4;
  localparam int TMO   = 255;
  localparam int LIMIT = TMO + 64;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_request;
  logic [7:0]  rd_address;
  logic        rd_enable;
  logic [7:0]  rd_address_out;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        tx_ready;
  UART_PACKET  tx;
  logic        busy;
  logic        error;

  int tests_run    = 0;
  int tests_failed = 0;

  byte_q_t    cap_data;
  logic       cap_sop[$];
  logic       cap_eop[$];
  int         meta_bad;
  int         hold_bad;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  UART_PACKET prev_tx;

  int         obs_first, obs_end, obs_err_k, obs_err_cnt, obs_rden_cnt;
  logic       obs_rden0;
  logic [7:0] obs_addr0;

  read_responder #(
    .DATA_LENGTH (DLEN),
    .SOURCE_ID   (8'h01),
    .DEST_ID     (8'h00),
    .TIMEOUT     (TMO)
  ) dut (
    .ipClk       (clk),
    .ipReset     (rst),
    .ipRdRequest (rd_request),
    .ipRdAddress (rd_address),
    .opRdEnable  (rd_enable),
    .opRdAddress (rd_address_out),
    .ipRdData    (rd_data),
    .ipRdValid   (rd_valid),
    .ipTxReady   (tx_ready),
    .opTxStream  (tx),
    .opBusy      (busy),
    .opError     (error)
  );

  always #5 clk = ~clk;

  // Byte monitor: records every consumed byte and any change while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready &&
          (tx.Valid !== 1'b1 || tx.Data !== prev_tx.Data || tx.SoP !== prev_tx.SoP || tx.EoP !== prev_tx.EoP))
        hold_bad++;
      if (tx.Valid === 1'b1 && tx_ready) begin
        cap_data.push_back(tx.Data);
        cap_sop.push_back(tx.SoP);
        cap_eop.push_back(tx.EoP);
        if (tx.Length !== 8'(DLEN + 1) || tx.Source !== 8'h01 || tx.Destination !== 8'h00) meta_bad++;
      end
      prev_valid = tx.Valid;
      prev_ready = tx_ready;
      prev_tx    = tx;
    end
  end

  function automatic byte_q_t expect_packet(input logic [7:0] addr, input logic [31:0] data);
    byte_q_t q;
    q.push_back(addr);
    for (int i = 0; i < DLEN; i++) q.push_back(8'((data >> (8 * (DLEN - 1 - i))) & 32'hFF));
    return q;
  endfunction

  function automatic string q2s(input byte_q_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic bit same_q(input byte_q_t a, input byte_q_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit flags_ok();
    int n = cap_sop.size();
    if (n == 0) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if (cap_sop[i] !== (i == 0)) return 1'b0;
      if (cap_eop[i] !== (i == n - 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One read transaction; k counts cycles from the cycle after the request edge.
  task automatic run_txn(input logic [7:0] addr, input logic [31:0] data, input int lat,
                         input bit give_valid, input int mode, input int req_at, input int rst_at);
    int k;
    cap_data.delete(); cap_sop.delete(); cap_eop.delete();
    meta_bad = 0; hold_bad = 0;
    obs_first = -1; obs_end = -1; obs_err_k = -1; obs_err_cnt = 0; obs_rden_cnt = 0;
    rd_request = 1'b1; rd_address = addr;
    @(posedge clk); #1;
    rd_request = 1'b0; rd_address = 8'($urandom);
    obs_rden0 = rd_enable; obs_addr0 = rd_address_out;
    k = 0;
    while (k < LIMIT) begin
      if (error) begin obs_err_cnt++; if (obs_err_k < 0) obs_err_k = k; end
      if (rd_enable) obs_rden_cnt++;
      if (tx.Valid && obs_first < 0) obs_first = k;
      if (!busy) begin obs_end = k; break; end
      rd_valid = (give_valid && k == lat) ||
                 (mode == 2 && give_valid && k > lat + 1 && $urandom_range(0, 3) == 0);
      rd_data  = (give_valid && k == lat) ? data : $urandom;
      tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      rd_request = (k == req_at);
      if (k == req_at) rd_address = 8'h09;
      rst = (k == rst_at);
      @(posedge clk); #1;
      if (rst) begin rst = 1'b0; obs_end = k + 1; break; end
      k++;
    end
    rd_valid = 1'b0; rd_request = 1'b0; tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_request = 1'b1; rd_address = 8'($urandom); rd_valid = 1'b1; rd_data = $urandom; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (rd_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_enable: got %b expected 0", rd_enable); end
    tests_run++; if (rd_address_out !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_address: got %h expected 00", rd_address_out); end
    tests_run++; if (tx !== '0) begin tests_failed++; $display("FAIL reset_stream: got %h expected 0", tx); end
    tests_run++; if (busy !== 1'b0 || error !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_error: got %b%b expected 00", busy, error); end
    rd_request = 1'b0; rd_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    byte_q_t exp = expect_packet(8'h05, 32'hA1B2C3D4);
    run_txn(8'h05, 32'hA1B2C3D4, 1, 1'b1, 0, -1, -1);
    tests_run++; if (obs_rden0 !== 1'b1 || obs_addr0 !== 8'h05 || obs_rden_cnt != 1) begin tests_failed++;
      $display("FAIL basic_rd_strobe: got en=%b addr=%h pulses=%0d expected en=1 addr=05 pulses=1", obs_rden0, obs_addr0, obs_rden_cnt); end
    tests_run++; if (!same_q(cap_data, exp)) begin tests_failed++; $display("FAIL basic_bytes: got %s expected %s", q2s(cap_data), q2s(exp)); end
    tests_run++; if (!flags_ok() || meta_bad != 0) begin tests_failed++; $display("FAIL basic_fields: got meta_bad=%0d flags_ok=%b expected 0/1", meta_bad, flags_ok()); end
    tests_run++; if (obs_first != 2 || obs_end != obs_first + DLEN + 1) begin tests_failed++;
      $display("FAIL basic_timing: got first=%0d end=%0d expected first=2 end=%0d", obs_first, obs_end, 2 + DLEN + 1); end
    tests_run++; if (obs_err_cnt != 0) begin tests_failed++; $display("FAIL basic_error: got %0d pulses expected 0", obs_err_cnt); end
  endtask

  task automatic test_backpressure();
    byte_q_t exp = expect_packet(8'h05, 32'hA1B2C3D4);
    run_txn(8'h05, 32'hA1B2C3D4, 1, 1'b1, 1, -1, -1);
    tests_run++; if (!same_q(cap_data, exp)) begin tests_failed++; $display("FAIL bp_bytes: got %s expected %s", q2s(cap_data), q2s(exp)); end
    tests_run++; if (hold_bad != 0 || !flags_ok()) begin tests_failed++; $display("FAIL bp_hold: got hold_bad=%0d flags_ok=%b expected 0/1", hold_bad, flags_ok()); end
  endtask

  task automatic test_timeout();
    byte_q_t exp = expect_packet(8'h05, 32'hFFFFFFFF);
    run_txn(8'h05, 32'h0, 0, 1'b0, 0, -1, -1);
    tests_run++; if (obs_err_cnt != 1 || obs_err_k != TMO) begin tests_failed++;
      $display("FAIL timeout_error: got pulses=%0d at=%0d expected 1 at %0d", obs_err_cnt, obs_err_k, TMO); end
    tests_run++; if (!same_q(cap_data, exp)) begin tests_failed++; $display("FAIL timeout_bytes: got %s expected %s", q2s(cap_data), q2s(exp)); end
    tests_run++; if (obs_end != TMO + DLEN + 1 || !flags_ok()) begin tests_failed++;
      $display("FAIL timeout_end: got end=%0d expected %0d", obs_end, TMO + DLEN + 1); end
  endtask

  task automatic test_coincide();
    logic [31:0] d = $urandom;
    byte_q_t exp = expect_packet(8'h33, d);
    run_txn(8'h33, d, TMO - 1, 1'b1, 0, -1, -1);
    tests_run++; if (obs_err_cnt != 0) begin tests_failed++; $display("FAIL coincide_error: got %0d pulses expected 0", obs_err_cnt); end
    tests_run++; if (!same_q(cap_data, exp) || obs_first != TMO) begin tests_failed++;
      $display("FAIL coincide_bytes: got %s first=%0d expected %s first=%0d", q2s(cap_data), obs_first, q2s(exp), TMO); end
  endtask

  task automatic test_ignore_request();
    byte_q_t exp = expect_packet(8'h05, 32'hA1B2C3D4);
    logic [31:0] d = $urandom;
    byte_q_t exp9 = expect_packet(8'h09, d);
    int seen;
    // spurious request mid-data, then one on the cycle the EoP byte is accepted
    for (int t = 0; t < 2; t++) begin
      run_txn(8'h05, 32'hA1B2C3D4, 1, 1'b1, 0, (t == 0) ? 4 : 2 + DLEN, -1);
      tests_run++; if (!same_q(cap_data, exp) || rd_address_out !== 8'h05) begin tests_failed++;
        $display("FAIL ignore_req_bytes%0d: got %s addr=%h expected %s addr=05", t, q2s(cap_data), rd_address_out, q2s(exp)); end
      seen = 0;
      repeat (3) begin @(posedge clk); #1; if (busy || rd_enable || tx.Valid) seen++; end
      tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL ignore_req_queued%0d: got %0d active cycles expected 0", t, seen); end
    end
    run_txn(8'h09, d, 3, 1'b1, 0, -1, -1);
    tests_run++; if (!same_q(cap_data, exp9)) begin tests_failed++; $display("FAIL ignore_req_next: got %s expected %s", q2s(cap_data), q2s(exp9)); end
  endtask

  task automatic test_reset_midpacket();
    byte_q_t exp3;
    logic [31:0] d = $urandom;
    byte_q_t expd = expect_packet(8'h5A, d);
    exp3.push_back(8'h05); exp3.push_back(8'hA1); exp3.push_back(8'hB2);
    run_txn(8'h05, 32'hA1B2C3D4, 1, 1'b1, 0, -1, 5);
    tests_run++; if (tx !== '0 || busy !== 1'b0 || rd_enable !== 1'b0 || rd_address_out !== 8'h00 || error !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_outputs: got tx=%h busy=%b en=%b addr=%h err=%b expected all 0", tx, busy, rd_enable, rd_address_out, error); end
    tests_run++; if (!same_q(cap_data, exp3) || cap_eop[cap_eop.size()-1] !== 1'b0) begin tests_failed++;
      $display("FAIL midreset_partial: got %s expected %s without EoP", q2s(cap_data), q2s(exp3)); end
    run_txn(8'h5A, d, 2, 1'b1, 0, -1, -1);
    tests_run++; if (!same_q(cap_data, expd) || !flags_ok()) begin tests_failed++; $display("FAIL midreset_recover: got %s expected %s", q2s(cap_data), q2s(expd)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0]  a = 8'($urandom);
      logic [31:0] d = $urandom;
      int          l = $urandom_range(1, 20);
      byte_q_t     exp = expect_packet(a, d);
      run_txn(a, d, l, 1'b1, 2, -1, -1);
      tests_run++; if (!same_q(cap_data, exp) || hold_bad != 0 || meta_bad != 0 || !flags_ok() || obs_err_cnt != 0 || obs_first != l + 1) begin
        tests_failed++; $display("FAIL random%0d: got %s hold=%0d meta=%0d err=%0d first=%0d expected %s first=%0d",
                                 n, q2s(cap_data), hold_bad, meta_bad, obs_err_cnt, obs_first, q2s(exp), l + 1); end
    end
  endtask

  initial begin
    rst = 1'b1; rd_request = 1'b0; rd_address = 8'h00; rd_data = 32'h0; rd_valid = 1'b0; tx_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_coincide();
    test_ignore_request();
    test_reset_midpacket();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
